sr_alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the core ALU. Executes single-cycle integer ops plus iterative unsigned multiply and divide, all through a start/busy/done handshake.
- Sits in the execute stage. The control unit asserts start and stalls the PC while busy is high.
- Result and flags are registered and held stable until the next accepted start.

---
 rtl/sr_alu_mc_pkg.sv | 42 ++++
 rtl/sr_alu_iter.sv | 81 ++++++++
 rtl/sr_alu_mc.sv | 121 ++++++++++++
 tb/tb_sr_alu_mc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: 4-bit op codes, FSM states and engine modes.
package sr_alu_mc_pkg;

    localparam int unsigned OPW = 4;

    // The original 3-bit codes keep their values; the iterative ops extend the space.
    typedef enum logic [OPW-1:0] {
        ALU_ADD   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_SRL   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_SUB   = 4'd4,
        ALU_AND   = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SLT   = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

    function automatic logic is_iter_op(input logic [OPW-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic is_div_op(input logic [OPW-1:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/sr_alu_iter.sv
// Radix-2 iterative engine: shift-add unsigned multiply and restoring unsigned divide.
// hi/lo present the post-step values so the caller can capture the final step directly.
module sr_alu_iter
    import sr_alu_mc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  iter_mode_e      mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            last
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] sr_q;
    logic [XLEN-1:0] b_q;
    logic [SHW-1:0]  cnt_q;
    iter_mode_e      mode_q;

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // One step: mul adds b into the accumulator and shifts {acc,sr} right;
    // div shifts {rem,quot} left and subtracts b when it fits.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, b_q};
        shifted = {acc_q, sr_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        hi      = acc_q;
        lo      = sr_q;
        if (mode_q == MODE_MUL) begin
            if (sr_q[0]) begin
                hi = sum[XLEN:1];
                lo = {sum[0], sr_q[XLEN-1:1]};
            end else begin
                hi = {1'b0, acc_q[XLEN-1:1]};
                lo = {acc_q[0], sr_q[XLEN-1:1]};
            end
        end else begin
            if (shifted >= {1'b0, b_q}) begin
                hi = diff[XLEN-1:0];
                lo = {sr_q[XLEN-2:0], 1'b1};
            end else begin
                hi = shifted[XLEN-1:0];
                lo = {sr_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign last = (cnt_q == SHW'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sr_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_MUL;
        end else if (load) begin
            acc_q  <= '0;
            sr_q   <= a;
            b_q    <= b;
            cnt_q  <= '0;
            mode_q <= mode;
        end else if (step) begin
            acc_q  <= hi;
            sr_q   <= lo;
            cnt_q  <= SHW'(cnt_q + 1'b1);
        end
    end

endmodule

// File: rtl/sr_alu_mc.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative MUL/MULHU/DIVU/REMU behind start/busy/done.
module sr_alu_mc
    import sr_alu_mc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      oper,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            less
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic            accept_c, load_c, step_c, fin_c;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] sc_res;
    logic [XLEN-1:0] it_hi, it_lo;
    logic            it_last;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    iter_mode_e      mode_c;

    assign shamt  = srcB[SHW-1:0];
    assign lt_s   = $signed(srcA) < $signed(srcB);
    assign mode_c = is_div_op(oper) ? MODE_DIV : MODE_MUL;

    // Single-cycle datapath; unknown codes fall through to ADD.
    always_comb begin
        sc_res = srcA + srcB;
        case (alu_op_e'(oper))
            ALU_SUB:  sc_res = srcA - srcB;
            ALU_AND:  sc_res = srcA & srcB;
            ALU_OR:   sc_res = srcA | srcB;
            ALU_XOR:  sc_res = srcA ^ srcB;
            ALU_SLL:  sc_res = srcA << shamt;
            ALU_SRL:  sc_res = srcA >> shamt;
            ALU_SRA:  sc_res = XLEN'($signed(srcA) >>> shamt);
            ALU_SLT:  sc_res = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: sc_res = {{(XLEN-1){1'b0}}, (srcA < srcB)};
            default:  sc_res = srcA + srcB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        load_c   = 1'b0;
        step_c   = 1'b0;
        fin_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (is_iter_op(oper)) begin
                        load_c  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                if (it_last) begin
                    fin_c   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sr_alu_iter #(.XLEN(XLEN)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .step  (step_c),
        .mode  (mode_c),
        .a     (srcA),
        .b     (srcB),
        .hi    (it_hi),
        .lo    (it_lo),
        .last  (it_last)
    );

    // Output registers; result/less hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            less   <= 1'b0;
            done   <= 1'b0;
            op_q   <= ALU_ADD;
        end else begin
            done <= (accept_c && !load_c) || fin_c;
            if (accept_c) begin
                less <= lt_s;
                op_q <= oper;
                if (!load_c) result <= sc_res;
            end
            if (fin_c) begin
                result <= ((op_q == ALU_MUL) || (op_q == ALU_DIVU)) ? it_lo : it_hi;
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign zero = (result == '0);

endmodule

// File: tb/tb_sr_alu_mc.sv
// Directed bench for sr_alu_mc at XLEN=32 and XLEN=8 with hand-computed expectations.
module tb_sr_alu_mc;
    import sr_alu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        use8 = 1'b0;
    logic [3:0]  oper = 4'd0;
    logic [63:0] srca = '0;
    logic [63:0] srcb = '0;
    logic [63:0] msk = 64'hFFFF_FFFF;
    int          xlen = 32;

    logic        busy32, done32, zero32, less32;
    logic [31:0] result32;
    logic        busy8, done8, zero8, less8;
    logic [7:0]  result8;
    logic        start32, start8;

    logic        busy_o, done_o, zero_o, less_o;
    logic [63:0] res_o;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    assign start32 = start & ~use8;
    assign start8  = start & use8;

    assign busy_o = use8 ? busy8 : busy32;
    assign done_o = use8 ? done8 : done32;
    assign zero_o = use8 ? zero8 : zero32;
    assign less_o = use8 ? less8 : less32;
    assign res_o  = use8 ? {56'd0, result8} : {32'd0, result32};

    sr_alu_mc #(.XLEN(32)) u_dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start32),
        .oper   (oper),
        .srcA   (srca[31:0]),
        .srcB   (srcb[31:0]),
        .busy   (busy32),
        .done   (done32),
        .result (result32),
        .zero   (zero32),
        .less   (less32)
    );

    sr_alu_mc #(.XLEN(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .oper   (oper),
        .srcA   (srca[7:0]),
        .srcB   (srcb[7:0]),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .zero   (zero8),
        .less   (less8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (xlen=%0d): got %0h expected %0h", tag, xlen, got, exp);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_r, input logic exp_less, input string tag);
        int cyc;
        logic [63:0] e;
        e = exp_r & msk;
        @(negedge clk);
        start = 1'b1; oper = op; srca = a; srcb = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (is_iter_op(op)) begin
            chk({tag, "_busy_start"}, 64'(busy_o), 64'd1);
            cyc = 0;
            while (busy_o && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk({tag, "_latency"}, 64'(cyc), 64'(xlen));
        end else begin
            chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        end
        chk({tag, "_done"}, 64'(done_o), 64'd1);
        chk({tag, "_result"}, res_o, e);
        chk({tag, "_zero"}, 64'(zero_o), 64'(e == 64'd0));
        chk({tag, "_less"}, 64'(less_o), 64'(exp_less));
    endtask

    task automatic run_suite(input logic w8);
        int cyc;
        int ndone;
        int rst_at;
        use8 = w8;
        xlen = w8 ? 8 : 32;
        msk  = w8 ? 64'hFF : 64'hFFFF_FFFF;
        rst_at = w8 ? 4 : 10;

        run_op(ALU_ADD, ONES, 64'd1, 64'd0, 1'b1, "add_wrap");
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("result_hold", res_o, 64'd0);

        run_op(ALU_SRA, w8 ? 64'h80 : 64'h8000_0000, 64'h24,
               w8 ? 64'hF8 : 64'hF800_0000, 1'b1, "sra");
        run_op(ALU_SLT,  ONES, 64'd1, 64'd1, 1'b1, "slt");
        run_op(ALU_SLTU, ONES, 64'd1, 64'd0, 1'b1, "sltu");
        run_op(ALU_SUB,  64'd5, 64'd7, ONES - 64'd1, 1'b1, "sub");
        run_op(ALU_XOR,  64'h5A, 64'h0F, 64'h55, 1'b0, "xor");
        run_op(4'd15,    64'd3, 64'd4, 64'd7, 1'b1, "undef_add");

        run_op(ALU_MUL,   ONES, ONES, 64'd1, 1'b0, "mul");
        run_op(ALU_MULHU, ONES, ONES, ONES - 64'd1, 1'b0, "mulhu");
        run_op(ALU_DIVU,  64'd100, 64'd7, 64'd14, 1'b0, "divu");
        run_op(ALU_REMU,  64'd100, 64'd7, 64'd2, 1'b0, "remu");
        run_op(ALU_DIVU,  64'd5, 64'd0, ONES, 1'b0, "divu_zero");
        run_op(ALU_REMU,  64'd123, 64'd0, 64'd123, 1'b0, "remu_zero");

        // Mid-run start and operand changes must not disturb the divide.
        @(negedge clk);
        start = 1'b1; oper = ALU_DIVU; srca = 64'd100; srcb = 64'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; oper = ALU_ADD; srca = 64'd5; srcb = 64'd9;
        @(negedge clk);
        start = 1'b0; srca = 64'd200; srcb = 64'd3;
        cyc = 0;
        #1;
        while (busy_o && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ign_done", 64'(done_o), 64'd1);
        chk("ign_result", res_o, 64'd14);
        // Back-to-back accept in the done cycle.
        start = 1'b1; oper = ALU_ADD; srca = 64'd3; srcb = 64'd4;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done", 64'(done_o), 64'd1);
        chk("b2b_result", res_o, 64'd7);
        chk("b2b_busy", 64'(busy_o), 64'd0);

        // Reset mid-multiply aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; oper = ALU_MUL; srca = ONES; srcb = ONES;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (rst_at - 1) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_result", res_o, 64'd0);
        chk("rst_zero", 64'(zero_o), 64'd1);
        chk("rst_less", 64'(less_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (xlen + 4) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        chk("rst_idle_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        use8 = 1'b0;
        chk("reset_busy32", 64'(busy_o), 64'd0);
        chk("reset_done32", 64'(done_o), 64'd0);
        chk("reset_result32", res_o, 64'd0);
        chk("reset_zero32", 64'(zero_o), 64'd1);
        chk("reset_less32", 64'(less_o), 64'd0);
        use8 = 1'b1;
        chk("reset_busy8", 64'(busy_o), 64'd0);
        chk("reset_result8", res_o, 64'd0);
        chk("reset_zero8", 64'(zero_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_suite(1'b0);
        run_suite(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
